// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module  : divider_pkg
// Brief   : State encodings, handshake levels and helpers for the divider.
// Rev     : 1.0  initial release
// ============================================================================
package divider_pkg;

   localparam int unsigned c_DATA_W = 32;
   localparam logic [5:0]  c_ITER_LAST = 6'd32;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   // Two's-complement magnitude when the operand is treated as signed.
   function automatic logic [c_DATA_W-1:0] mag(input logic [c_DATA_W-1:0] v,
                                               input logic is_signed);
      return (is_signed && v[c_DATA_W-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/divider_if.sv
`default_nettype none
// ============================================================================
// Module  : divider_if
// Brief   : EX-stage <-> divider request/result bundle.
// Rev     : 1.0  initial release
// ============================================================================
interface divider_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface
`default_nettype wire

// File: rtl/divider_div_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Brief   : One restoring-division iteration on the 65-bit dividend register.
// Rev     : 1.0  initial release
// ============================================================================
module div_step (
   input  logic [64:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic [64:0] o_dividend
);

   logic        w_borrow;
   logic [31:0] w_diff;

   // Minuend is the full 33-bit {remainder, next bit} so divisors above 2^31 stay exact.
   assign w_borrow = i_dividend[64:32] < {1'b0, i_divisor};
   assign w_diff   = i_dividend[63:32] - i_divisor;

   always_comb begin
      o_dividend = {i_dividend[63:0], 1'b0};
      if (!w_borrow) begin
         o_dividend = {w_diff, i_dividend[31:0], 1'b1};
      end
   end

endmodule
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module  : divider
// Brief   : 32-bit radix-2 restoring divider (DIV/DIVU), one bit per clock.
//           DIV_EARLY_TERM_EN: finish immediately when |dividend| < |divisor|.
// Rev     : 1.0  initial release
// ============================================================================
module divider
   import divider_pkg::*;
(
   input  wire logic clk,
   input  wire logic rst,
   divider_if.slave  bus
);

   div_state_e  r_state,    w_state_nxt;
   logic [64:0] r_dividend, w_dividend_nxt, w_step;
   logic [31:0] r_divisor,  w_divisor_nxt;
   logic [5:0]  r_cnt,      w_cnt_nxt;
   logic        r_op1_neg,  w_op1_neg_nxt;
   logic        r_op2_neg,  w_op2_neg_nxt;
   logic        r_signed,   w_signed_nxt;
   logic [63:0] r_result,   w_result_nxt;
   logic        r_ready,    w_ready_nxt;
   logic [31:0] w_op1_abs, w_op2_abs, w_quot, w_rem;

   assign w_op1_abs = mag(bus.opdata1_i, bus.signed_div_i);
   assign w_op2_abs = mag(bus.opdata2_i, bus.signed_div_i);

   assign w_quot = (r_signed && (r_op1_neg ^ r_op2_neg)) ? (~r_dividend[31:0] + 1'b1)
                                                         : r_dividend[31:0];
   assign w_rem  = (r_signed && r_op1_neg) ? (~r_dividend[64:33] + 1'b1)
                                           : r_dividend[64:33];

   div_step u_step (
      .i_dividend (r_dividend),
      .i_divisor  (r_divisor),
      .o_dividend (w_step)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= DIV_FREE;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_cnt      <= '0;
         r_op1_neg  <= 1'b0;
         r_op2_neg  <= 1'b0;
         r_signed   <= 1'b0;
         r_result   <= '0;
         r_ready    <= DIV_RESULT_NOT_READY;
      end else begin
         r_state    <= w_state_nxt;
         r_dividend <= w_dividend_nxt;
         r_divisor  <= w_divisor_nxt;
         r_cnt      <= w_cnt_nxt;
         r_op1_neg  <= w_op1_neg_nxt;
         r_op2_neg  <= w_op2_neg_nxt;
         r_signed   <= w_signed_nxt;
         r_result   <= w_result_nxt;
         r_ready    <= w_ready_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_dividend_nxt = r_dividend;
      w_divisor_nxt  = r_divisor;
      w_cnt_nxt      = r_cnt;
      w_op1_neg_nxt  = r_op1_neg;
      w_op2_neg_nxt  = r_op2_neg;
      w_signed_nxt   = r_signed;
      w_result_nxt   = r_result;
      w_ready_nxt    = r_ready;

      case (r_state)
         DIV_FREE: begin
            if (bus.start_i == DIV_START && !bus.annul_i) begin
               if (bus.opdata2_i == '0) begin
                  w_state_nxt = DIV_BY_ZERO;
`ifdef DIV_EARLY_TERM_EN
               end else if (w_op1_abs < w_op2_abs) begin
                  w_state_nxt  = DIV_END;
                  w_result_nxt = {bus.opdata1_i, 32'h0};
                  w_ready_nxt  = DIV_RESULT_READY;
`endif
               end else begin
                  w_state_nxt    = DIV_ON;
                  w_op1_neg_nxt  = bus.opdata1_i[31];
                  w_op2_neg_nxt  = bus.opdata2_i[31];
                  w_signed_nxt   = bus.signed_div_i;
                  w_divisor_nxt  = w_op2_abs;
                  w_dividend_nxt = {32'h0, w_op1_abs, 1'b0};
                  w_cnt_nxt      = '0;
               end
            end
         end
         DIV_BY_ZERO: begin
            w_state_nxt  = DIV_END;
            w_result_nxt = '0;
            w_ready_nxt  = DIV_RESULT_READY;
         end
         DIV_ON: begin
            if (bus.annul_i) begin
               w_state_nxt  = DIV_FREE;
               w_result_nxt = '0;
               w_ready_nxt  = DIV_RESULT_NOT_READY;
            end else if (r_cnt == c_ITER_LAST) begin
               w_state_nxt  = DIV_END;
               w_result_nxt = {w_rem, w_quot};
               w_ready_nxt  = DIV_RESULT_READY;
            end else begin
               w_dividend_nxt = w_step;
               w_cnt_nxt      = r_cnt + 6'd1;
            end
         end
         DIV_END: begin
            // Result stays up until EX drops the request.
            if (bus.start_i == DIV_STOP) begin
               w_state_nxt  = DIV_FREE;
               w_result_nxt = '0;
               w_ready_nxt  = DIV_RESULT_NOT_READY;
            end
         end
         default: begin
            w_state_nxt = DIV_FREE;
         end
      endcase
   end

   assign bus.result_o = r_result;
   assign bus.ready_o  = r_ready;

endmodule
`default_nettype wire
